// File: rtl/dtw_traceback_if.sv
// Handshake/bus bundle for the DTW traceback stage: lane capture bus,
// trace command and the path-point output stream.
interface dtw_traceback_if #(
   parameter int NPE = 6,
   parameter int IW  = 5
);
   logic                  ena;
   logic [NPE*IW-1:0]     i_tindex;
   logic [NPE*IW-1:0]     i_rindex;
   logic [2*NPE-1:0]      i_path;
   logic [NPE-1:0]        i_pvalid;
   logic [IW-1:0]         i_tlast;
   logic [IW-1:0]         i_rlast;
   logic                  i_trace;
   logic                  o_pt_valid;
   logic [IW-1:0]         o_pt_t;
   logic [IW-1:0]         o_pt_r;
   logic                  o_pt_last;
   logic                  i_pt_ready;
   logic                  o_busy;
   logic                  o_done;
   logic [IW:0]           o_count;

   modport master (
      output ena, i_tindex, i_rindex, i_path, i_pvalid, i_tlast, i_rlast, i_trace, i_pt_ready,
      input  o_pt_valid, o_pt_t, o_pt_r, o_pt_last, o_busy, o_done, o_count
   );

   modport slave (
      input  ena, i_tindex, i_rindex, i_path, i_pvalid, i_tlast, i_rlast, i_trace, i_pt_ready,
      output o_pt_valid, o_pt_t, o_pt_r, o_pt_last, o_busy, o_done, o_count
   );
endinterface

// File: rtl/dtw_traceback.sv
// DTW path memory plus traceback: captures per-lane predecessor decisions,
// then walks from (t_last, r_last) back to (0,0) streaming one point per accept.
module dtw_traceback_lane #(
   parameter int IW = 5
) (
   input  logic          ena,
   input  logic          idle,
   input  logic          pvalid,
   input  logic [IW-1:0] t_in,
   input  logic [IW-1:0] r_in,
   input  logic [1:0]    code_in,
   output logic          we,
   output logic [IW-1:0] t,
   output logic [IW-1:0] r,
   output logic [1:0]    code
);
   assign we   = ena && pvalid && idle;
   assign t    = t_in;
   assign r    = r_in;
   assign code = code_in;
endmodule

module dtw_traceback #(
   parameter int NPE = 6,
   parameter int IW  = 5
) (
   input logic           clk,
   input logic           nrst,
   dtw_traceback_if.slave bus
);
   localparam int DEPTH = 1 << IW;

   typedef enum logic {IDLE, TRACE} state_t;

   typedef struct packed {
      logic [IW-1:0] t;
      logic [IW-1:0] r;
      logic          last;
   } point_t;

   state_t                    state;
   point_t                    pt;
   logic                      pt_valid;
   logic                      busy;
   logic                      done;
   logic [IW:0]               count;
   logic                      idle;

   logic [NPE-1:0][IW-1:0]    tix;
   logic [NPE-1:0][IW-1:0]    rix;
   logic [NPE-1:0][1:0]       pix;

   logic [NPE-1:0]            lane_we;
   logic [NPE-1:0][IW-1:0]    lane_t;
   logic [NPE-1:0][IW-1:0]    lane_r;
   logic [NPE-1:0][1:0]       lane_c;

   logic [1:0]                mem [DEPTH][DEPTH];
   logic [1:0]                cur_code;
   logic [IW-1:0]             nxt_t;
   logic [IW-1:0]             nxt_r;
   logic                      accept;

   assign idle = (state == IDLE);
   assign tix  = bus.i_tindex;
   assign rix  = bus.i_rindex;
   assign pix  = bus.i_path;

   // Lane k lives in the most-significant field first, hence the NPE-1-k flip.
   generate
      for (genvar k = 0; k < NPE; k++) begin : g_lane
         dtw_traceback_lane #(.IW(IW)) u_lane (
            .ena     (bus.ena),
            .idle    (idle),
            .pvalid  (bus.i_pvalid[NPE-1-k]),
            .t_in    (tix[NPE-1-k]),
            .r_in    (rix[NPE-1-k]),
            .code_in (pix[NPE-1-k]),
            .we      (lane_we[k]),
            .t       (lane_t[k]),
            .r       (lane_r[k]),
            .code    (lane_c[k])
         );
      end
   endgenerate

   // Path memory has no reset; ascending lane order makes the highest lane win a collision.
   always_ff @(posedge clk) begin
      for (int k = 0; k < NPE; k++) begin
         if (lane_we[k]) mem[lane_t[k]][lane_r[k]] <= lane_c[k];
      end
   end

   assign cur_code = mem[pt.t][pt.r];
   assign accept   = pt_valid && bus.i_pt_ready;

   // Edges of the grid override the stored decision; 2'b11 off-origin behaves as diagonal.
   always_comb begin
      nxt_t = pt.t;
      nxt_r = pt.r;
      if (pt.t == '0) begin
         nxt_r = pt.r - 1'b1;
      end else if (pt.r == '0) begin
         nxt_t = pt.t - 1'b1;
      end else begin
         case (cur_code)
            2'b01:   nxt_t = pt.t - 1'b1;
            2'b10:   nxt_r = pt.r - 1'b1;
            default: begin
               nxt_t = pt.t - 1'b1;
               nxt_r = pt.r - 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state    <= IDLE;
         pt       <= '0;
         pt_valid <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         count    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.i_trace) begin
                  state    <= TRACE;
                  pt.t     <= bus.i_tlast;
                  pt.r     <= bus.i_rlast;
                  pt.last  <= (bus.i_tlast == '0) && (bus.i_rlast == '0);
                  pt_valid <= 1'b1;
                  busy     <= 1'b1;
                  count    <= '0;
               end
            end
            TRACE: begin
               if (accept) begin
                  count <= count + 1'b1;
                  if (pt.last) begin
                     state    <= IDLE;
                     pt_valid <= 1'b0;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                  end else begin
                     pt.t    <= nxt_t;
                     pt.r    <= nxt_r;
                     pt.last <= (nxt_t == '0) && (nxt_r == '0);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.o_pt_valid = pt_valid;
   assign bus.o_pt_t     = pt.t;
   assign bus.o_pt_r     = pt.r;
   assign bus.o_pt_last  = pt.last;
   assign bus.o_busy     = busy;
   assign bus.o_done     = done;
   assign bus.o_count    = count;
endmodule

// File: doc/dtw_traceback.md
# dtw_traceback

Path-memory and traceback stage sitting directly downstream of the 6-PE DTW systolic array. Each cycle it captures the up-to-six 2-bit predecessor decisions the array emits, tagged with their (t, r) cell indices, into a 32x32 path memory. On command it walks back from the final cell (t_last, r_last) to (0, 0) and streams the warping path out one point per handshake.

## Interface
- NPE, 6, number of PE lanes (path 2*NPE bits, index 5*NPE bits)
- IW, 5, index width; memory is 2^IW x 2^IW cells of 2 bits

- clk  in  1  clock, all logic on rising edge
- nrst  in  1  synchronous active-low reset
- ena  in  1  capture enable, same cycle as array outputs
- i_tindex  in  30  per-lane t index, lane k at [29-5k : 25-5k]
- i_rindex  in  30  per-lane r index, same packing
- i_path  in  12  per-lane decision, lane k at [11-2k : 10-2k]
- i_pvalid  in  6  per-lane valid, lane k at bit 5-k
- i_tlast  in  5  last t index (length-1), sampled with i_trace
- i_rlast  in  5  last r index, sampled with i_trace
- i_trace  in  1  start traceback (pulse)
- o_pt_valid  out  1  path point valid
- o_pt_t  out  5  point t index
- o_pt_r  out  5  point r index
- o_pt_last  out  1  point is (0,0), final point
- i_pt_ready  in  1  consumer ready
- o_busy  out  1  high in TRACE
- o_done  out  1  one-cycle pulse after final point accepted
- o_count  out  6  points emitted in last traceback, held until next i_trace

## Operation
- Decision encoding: 2'b00 diagonal to (t-1,r-1); 2'b01 to (t-1,r); 2'b10 to (t,r-1); 2'b11 origin/none.
- States: IDLE, TRACE. Reset -> IDLE.
- Capture (IDLE only): for each lane k with ena && i_pvalid[k], mem[t_k][r_k] <= path_k. Two lanes hitting same cell same cycle: higher lane index k wins. Capture ignored in TRACE.
- Memory is not reset; cells not written since reset read undefined. Correct behaviour requires every cell on the path to be written before i_trace.
- IDLE -> TRACE on i_trace: cursor <= (i_tlast, i_rlast), o_count <= 0. i_trace in TRACE ignored. i_trace and capture in same cycle: capture performed, trace starts.
- TRACE: output point = cursor; o_pt_last = (cursor == 0,0). On accept (o_pt_valid && i_pt_ready): o_count += 1; if last -> IDLE, o_done pulse; else cursor steps by mem[cursor] with boundary override: t==0 forces step r-1; r==0 forces step t-1; code 2'b11 away from origin treated as diagonal (clamped by boundary rules).
- Single-cell case (i_tlast=i_rlast=0): one point, o_pt_last=1.
- Max path length 63 (o_count 6 bits, no wrap).

## Timing
- Reset values: o_pt_valid=0, o_pt_t=0, o_pt_r=0, o_pt_last=0, o_busy=0, o_done=0, o_count=0; state IDLE.
- Capture write visible to traceback the cycle after it is sampled.
- i_trace sampled at edge n -> o_pt_valid=1, o_busy=1 from cycle n+1.
- o_pt_* registered; held stable while o_pt_valid && !i_pt_ready.
- Accept at edge m -> next point valid at cycle m+1 (no bubble, full throughput 1 point/cycle with ready held high).
- Final accept at edge m -> cycle m+1: o_pt_valid=0, o_busy=0, o_done=1 for one cycle, o_count final.
- nrst low mid-trace -> next edge all outputs to reset values, IDLE; memory contents kept.

## Test plan
- Pure diagonal: write mem[i][i]=00 for i=0..4 (cell (0,0)=11), trace tlast=rlast=4, ready=1 -> points (4,4),(3,3),(2,2),(1,1),(0,0) on 5 consecutive cycles, last on (0,0), o_done next cycle, o_count=5.
- Boundary override: tlast=3, rlast=0, cells written 00 -> (3,0),(2,0),(1,0),(0,0), o_count=4; likewise tlast=0, rlast=2 -> (0,2),(0,1),(0,0).
- Backpressure: 4x4 mixed path, i_pt_ready toggled 1/0 each cycle -> points held stable while stalled, sequence identical to ready=1 run, 2x duration.
- Lane collision: lanes 1 and 4 write (2,2) same cycle with 01 and 10 -> trace through (2,2) steps to (2,1) (lane 4 wins).
- Capture lockout and reissue: during TRACE drive i_pvalid=6'h3F and i_trace=1 -> memory unchanged, traceback unaffected, no restart.
- Reset mid-trace: nrst low after 2 points -> all outputs 0 next cycle; re-trace same cell -> full correct path from memory.
